keyboard_event_queue: RTL and testbench
=======================================

# keyboard_event_queue

Controller between the PS/2 scan-code receiver and the `READKEY` path of the CPU. It decodes raw set-2 scan-code bytes, including the `E0` extended prefix and the `F0` break prefix, into complete key events. Events are buffered in a small FIFO. The head event is presented as `keycode`/`key_status` to the keyboard reader, and the reader consumes it with a one-cycle `pop`. This lets bytes arrive while the CPU is busy without losing key presses.

## Interface
- `DEPTH_LOG2`, default 3: FIFO holds 2^DEPTH_LOG2 events (8).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` holds a received scan byte.
- `rx_data`  in  8  scan-code byte.
- `rx_error`  in  1  one-cycle pulse on receiver parity/frame error.
- `pop`  in  1  one-cycle pulse; the reader has consumed the head event.
- `overflow_clr`  in  1  clears the sticky overflow flag.
- `keycode`  out  8  code of the head event; 0 when the FIFO is empty.
- `key_status`  out  8  status of the head event and the queue:
  - bit0 valid (FIFO non-empty)
  - bit1 is_break
  - bit2 is_extended
  - bit3 overflow (sticky)
  - bits7:4 occupancy, 0..8

## Operation
- Prefix FSM states: `IDLE`, `EXT`, `BRK`, `EXT_BRK`. Transitions on `rx_valid`:
  - `IDLE`: `E0` -> `EXT`; `F0` -> `BRK`; other byte -> push {ext=0, brk=0, code}, stay in `IDLE`.
  - `EXT`: `F0` -> `EXT_BRK`; `E0` -> stay in `EXT`; other byte -> push {1, 0, code}, go to `IDLE`.
  - `BRK`: any byte except `E0`/`F0` -> push {0, 1, code}, go to `IDLE`. `E0`/`F0` -> `IDLE`, no push (malformed sequence).
  - `EXT_BRK`: any byte except `E0`/`F0` -> push {1, 1, code}, go to `IDLE`. `E0`/`F0` -> `IDLE`, no push.
- Special bytes, in any state:
  - `00` and `FF` (keyboard overrun): set overflow, FSM -> `IDLE`, no push.
  - `AA` (BAT pass): FSM -> `IDLE`, no push.
- `rx_error`: FSM -> `IDLE`, no push, overflow unchanged. If `rx_error` and `rx_valid` are high together, `rx_error` wins and the byte is dropped.
- FIFO behaviour:
  - Push when full and no `pop` in the same cycle: event dropped, overflow set.
  - Push and `pop` in the same cycle when full: the pop frees a slot, the push succeeds, occupancy stays 8.
  - `pop` when empty: ignored.
  - Push and `pop` in the same cycle when empty: the pop is ignored and the push lands, giving occupancy 1.
- Overflow flag: set by a dropped push or an `00`/`FF` byte; cleared by `overflow_clr`. If a set and a clear occur in the same cycle, set wins.
- Pointers wrap modulo 2^DEPTH_LOG2. Occupancy is a DEPTH_LOG2+1 bit counter, zero-extended into bits7:4.

## Timing
- Reset value of every output is 0. Reset also sets the FSM to `IDLE`, empties the FIFO (pointers and count 0) and clears overflow.
- Reset asserted mid-sequence discards any pending prefix and all queued events.
- `keycode` and `key_status` are registered.
- A completing `rx_valid` in cycle n into an empty FIFO: `valid`=1 with the new code in cycle n+1.
- A prefix byte produces no output change.
- `pop` in cycle n: the next head (or zeros if the FIFO is now empty) appears in cycle n+1, and occupancy updates in n+1.
- The reader must not pulse `pop` unless `valid`=1 was sampled in the same cycle. At most one `pop` per event.
- Throughput: one byte accepted per cycle, no backpressure.

## Structure
- Shared package holds:
  - the constants `SC_EXT`=8'hE0, `SC_BRK`=8'hF0, `SC_BAT`=8'hAA, `SC_OVR0`=8'h00, `SC_OVR1`=8'hFF;
  - the `key_status` bit indices;
  - the FSM state encoding;
  - the `READKEY` opcode 6'b001001, shared with the reader.
- One sub-module, `kbd_event_fifo`: a synchronous FIFO with 10-bit entries {ext, brk, code[7:0]}, push/pop, full/empty/count outputs, and the same-cycle push+pop rules above.
- The prefix FSM, overflow flag and output registers live in the top module.

## Test plan
- Reset release, then bytes `1C`, `F0`, `1C` -> event 1: keycode=1C, status bit0=1, bit1=0. `pop` -> event 2: keycode=1C, bit1=1. `pop` -> keycode=0, status=0.
- `E0`, `F0`, `75` -> keycode=75, bit2=1, bit1=1, occupancy=1. No output change while the prefixes arrive.
- 9 make bytes with no pop -> occupancy=8, bit3=1, head is the first byte. On the 9th byte, push and `pop` in the same cycle instead -> no overflow, occupancy=8.
- `F0` then `rx_error`, then `1C` -> a single event {brk=0, 1C}. `FF` byte -> overflow=1, no event. `overflow_clr` together with an `00` byte -> overflow stays 1.
- `pop` while empty -> status stays 0. Push and `pop` in the same cycle while empty -> occupancy=1.
- `rst_n` low for 1 cycle after `E0` with 3 events queued -> all outputs 0. Then `74` -> {ext=0, 74}.

Source files
------------

// File: rtl/keyboard_event_queue_pkg.sv
// Shared definitions for the keyboard event queue: scan-code constants,
// key_status bit layout, prefix FSM encoding and the READKEY opcode.
package keyboard_event_queue_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_BAT  = 8'hAA;
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVR1 = 8'hFF;

    localparam int ST_VALID   = 0;
    localparam int ST_BRK     = 1;
    localparam int ST_EXT     = 2;
    localparam int ST_OVR     = 3;
    localparam int ST_OCC_LSB = 4;

    localparam logic [5:0] OP_READKEY = 6'b001001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    typedef struct packed {
        kbd_state_e state;
        logic       fifo_full;
        logic       fifo_empty;
        logic [3:0] fifo_count;
    } kbd_dbg_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK);
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == SC_OVR0) || (b == SC_OVR1);
    endfunction

endpackage

// File: rtl/keyboard_event_queue_fifo.sv
// Event FIFO of {ext, brk, code} entries. Also exposes the head/count as they
// will be after this edge so the top can register its outputs without lag.
module kbd_event_fifo
    import keyboard_event_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  kbd_event_t            i_push_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_nxt,
    output kbd_event_t            o_head_nxt,
    output logic                  o_dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH_LOG2'(0) | (DEPTH_LOG2+1)'(DEPTH);

    kbd_event_t              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;

    logic                    w_pop_ok;
    logic                    w_push_ok;
    logic [DEPTH_LOG2-1:0]   w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]     w_count_after_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_dropped = i_push & ~w_push_ok;

    assign w_rd_ptr_nxt      = r_rd_ptr + DEPTH_LOG2'(w_pop_ok);
    assign w_count_after_pop = r_count - (DEPTH_LOG2+1)'(w_pop_ok);
    assign o_count_nxt       = w_count_after_pop + (DEPTH_LOG2+1)'(w_push_ok);
    assign o_head_nxt        = (w_count_after_pop == '0) ? i_push_data : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= o_count_nxt;
        end
    end

endmodule

// File: rtl/keyboard_event_queue.sv
// Set-2 scan-code decoder (E0/F0 prefixes) feeding an event FIFO whose head
// is presented, registered, to the READKEY reader.
module keyboard_event_queue
    import keyboard_event_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_error,
    input  logic       i_pop,
    input  logic       i_overflow_clr,
    output logic [7:0] o_keycode,
    output logic [7:0] o_key_status,
    output kbd_dbg_t   o_dbg
);

    kbd_state_e            r_state;
    kbd_state_e            w_state_nxt;
    logic                  r_overflow;
    logic [7:0]            r_keycode;
    logic [7:0]            r_key_status;

    logic                  w_byte;
    logic                  w_push;
    kbd_event_t            w_push_data;
    logic                  w_ovr_byte;
    logic                  w_ovr_nxt;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_dropped;
    logic [DEPTH_LOG2:0]   w_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    kbd_event_t            w_head_nxt;

    // An errored cycle drops its byte entirely.
    assign w_byte = i_rx_valid & ~i_rx_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_rx_error) begin
            w_state_nxt = S_IDLE;
        end else if (i_rx_valid) begin
            if (is_overrun(i_rx_data) || (i_rx_data == SC_BAT)) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_rx_data == SC_EXT)      w_state_nxt = S_EXT;
                        else if (i_rx_data == SC_BRK) w_state_nxt = S_BRK;
                        else                          w_state_nxt = S_IDLE;
                    end
                    S_EXT: begin
                        if (i_rx_data == SC_BRK)      w_state_nxt = S_EXT_BRK;
                        else if (i_rx_data == SC_EXT) w_state_nxt = S_EXT;
                        else                          w_state_nxt = S_IDLE;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_ovr_byte  = 1'b0;
        if (w_byte) begin
            if (is_overrun(i_rx_data)) begin
                w_ovr_byte = 1'b1;
            end else if ((i_rx_data != SC_BAT) && !is_prefix(i_rx_data)) begin
                w_push           = 1'b1;
                w_push_data.code = i_rx_data;
                w_push_data.ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
                w_push_data.brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
            end
        end
    end

    kbd_event_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (i_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_head_nxt  (w_head_nxt),
        .o_dropped   (w_dropped)
    );

    // A set in the same cycle as a clear keeps the flag high.
    assign w_ovr_nxt = (w_ovr_byte | w_dropped) ? 1'b1 :
                       i_overflow_clr           ? 1'b0 : r_overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow   <= 1'b0;
            r_keycode    <= '0;
            r_key_status <= '0;
        end else begin
            r_overflow <= w_ovr_nxt;
            r_keycode  <= (w_count_nxt != '0) ? w_head_nxt.code : 8'h00;
            r_key_status[ST_VALID]          <= (w_count_nxt != '0);
            r_key_status[ST_BRK]            <= (w_count_nxt != '0) & w_head_nxt.brk;
            r_key_status[ST_EXT]            <= (w_count_nxt != '0) & w_head_nxt.ext;
            r_key_status[ST_OVR]            <= w_ovr_nxt;
            r_key_status[7:ST_OCC_LSB]      <= 4'(w_count_nxt);
        end
    end

    assign o_keycode        = r_keycode;
    assign o_key_status     = r_key_status;
    assign o_dbg.state      = r_state;
    assign o_dbg.fifo_full  = w_fifo_full;
    assign o_dbg.fifo_empty = w_fifo_empty;
    assign o_dbg.fifo_count = 4'(w_count);

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Directed table-driven bench for keyboard_event_queue plus a hand-written
// mid-sequence reset scenario.
module tb_keyboard_event_queue;
    import keyboard_event_queue_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       pop;
    logic       ovr_clr;
    logic [7:0] keycode;
    logic [7:0] key_status;
    kbd_dbg_t   dbg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       p;
        logic       c;
        logic [7:0] exp_kc;
        logic [7:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    keyboard_event_queue #(.DEPTH_LOG2(3)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_valid     (rx_valid),
        .i_rx_data      (rx_data),
        .i_rx_error     (rx_error),
        .i_pop          (pop),
        .i_overflow_clr (ovr_clr),
        .o_keycode      (keycode),
        .o_key_status   (key_status),
        .o_dbg          (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic v, input logic [7:0] d, input logic e,
                                input logic p, input logic c,
                                input logic [7:0] kc, input logic [7:0] st);
        vec_t t;
        t.v = v; t.d = d; t.e = e; t.p = p; t.c = c; t.exp_kc = kc; t.exp_st = st;
        vecs.push_back(t);
    endfunction

    // status = {occ[3:0], ovr, ext, brk, valid}
    function automatic logic [7:0] st(input int occ, input logic ovr, input logic ext,
                                      input logic brk);
        logic [3:0] o;
        o = 4'(occ);
        return {o, ovr, ext, brk, (occ != 0)};
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %02h expected %02h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e,
                         input logic p, input logic c);
        @(negedge clk);
        rx_valid = v; rx_data = d; rx_error = e; pop = p; ovr_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] drain_codes [8];
        rst_n = 1'b0; rx_valid = 0; rx_data = 0; rx_error = 0; pop = 0; ovr_clr = 0;

        // basic make / break / pop
        add(1, 8'h1C, 0, 0, 0, 8'h1C, st(1, 0, 0, 0));
        add(1, 8'hF0, 0, 0, 0, 8'h1C, st(1, 0, 0, 0));
        add(1, 8'h1C, 0, 0, 0, 8'h1C, st(2, 0, 0, 0));
        add(0, 8'h00, 0, 1, 0, 8'h1C, st(1, 0, 0, 1));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        // extended break
        add(1, 8'hE0, 0, 0, 0, 8'h00, 8'h00);
        add(1, 8'hF0, 0, 0, 0, 8'h00, 8'h00);
        add(1, 8'h75, 0, 0, 0, 8'h75, st(1, 0, 1, 1));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        // fill to 8, overflow on the 9th, clear, then push+pop while full
        for (int k = 1; k <= 8; k++) add(1, 8'(k), 0, 0, 0, 8'h01, st(k, 0, 0, 0));
        add(1, 8'h09, 0, 0, 0, 8'h01, st(8, 1, 0, 0));
        add(0, 8'h00, 0, 0, 1, 8'h01, st(8, 0, 0, 0));
        add(1, 8'h0A, 0, 1, 0, 8'h02, st(8, 0, 0, 0));
        drain_codes = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        for (int k = 1; k <= 7; k++) add(0, 8'h00, 0, 1, 0, drain_codes[k], st(8 - k, 0, 0, 0));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        // break prefix cancelled by rx_error
        add(1, 8'hF0, 0, 0, 0, 8'h00, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        add(1, 8'h1C, 0, 0, 0, 8'h1C, st(1, 0, 0, 0));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        // overrun bytes and set-beats-clear
        add(1, 8'hFF, 0, 0, 0, 8'h00, st(0, 1, 0, 0));
        add(1, 8'h00, 0, 0, 1, 8'h00, st(0, 1, 0, 0));
        add(0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        // pop while empty; push+pop while empty
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        add(1, 8'h33, 0, 1, 0, 8'h33, st(1, 0, 0, 0));
        // error wins over a simultaneous byte; BAT ignored
        add(1, 8'h44, 1, 0, 0, 8'h33, st(1, 0, 0, 0));
        add(1, 8'hAA, 0, 0, 0, 8'h33, st(1, 0, 0, 0));
        // malformed F0 E0 drops back to idle, next byte is a plain make
        add(1, 8'hF0, 0, 0, 0, 8'h33, st(1, 0, 0, 0));
        add(1, 8'hE0, 0, 0, 0, 8'h33, st(1, 0, 0, 0));
        add(1, 8'h12, 0, 0, 0, 8'h33, st(2, 0, 0, 0));
        add(0, 8'h00, 0, 1, 0, 8'h12, st(1, 0, 0, 0));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
        // E0 E0 stays extended
        add(1, 8'hE0, 0, 0, 0, 8'h00, 8'h00);
        add(1, 8'hE0, 0, 0, 0, 8'h00, 8'h00);
        add(1, 8'h6B, 0, 0, 0, 8'h6B, st(1, 0, 1, 0));
        add(0, 8'h00, 0, 1, 0, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("reset_kc", 0, keycode, 8'h00);
        check("reset_st", 0, key_status, 8'h00);
        check("reset_state", 0, 8'(dbg.state), 8'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].c);
            check("keycode", i, keycode, vecs[i].exp_kc);
            check("status", i, key_status, vecs[i].exp_st);
        end

        // three events queued, E0 pending, then a one-cycle reset
        drive(1, 8'h11, 0, 0, 0);
        drive(1, 8'h22, 0, 0, 0);
        drive(1, 8'h33, 0, 0, 0);
        drive(1, 8'hE0, 0, 0, 0);
        check("pre_rst_st", 0, key_status, st(3, 0, 0, 0));
        check("pre_rst_state", 0, 8'(dbg.state), 8'(S_EXT));
        @(negedge clk);
        rx_valid = 0; rx_data = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_kc", 0, keycode, 8'h00);
        check("mid_rst_st", 0, key_status, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h74, 0, 0, 0);
        check("post_rst_kc", 0, keycode, 8'h74);
        check("post_rst_st", 0, key_status, st(1, 0, 0, 0));
        drive(0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
